// File: rtl/regfile_pkg.sv
// Shared widths and the write-back entry type for the register file write path.
package regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 2 ** REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   value;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding LSU results that lost arbitration for the register file write port.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_eff, pop_eff;

  assign full     = (cnt_q == CntW'(Depth));
  assign empty    = (cnt_q == '0);
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_eff)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_eff && !pop_eff)      cnt_q <= cnt_q + 1'b1;
      else if (pop_eff && !push_eff) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and LSU results onto the single register file write port, with a pending
// scoreboard and write-stage forwarding for the issue stage.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned LSU_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_value,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_value,
  input  logic              sb_set_valid,
  input  logic [REG_AW-1:0] sb_set_rd,
  input  logic [REG_AW-1:0] src1_num,
  input  logic [REG_AW-1:0] src2_num,
  output logic              src1_busy,
  output logic              src2_busy,
  output logic              src1_fwd,
  output logic [XLEN-1:0]   src1_fwd_value,
  output logic              src2_fwd,
  output logic [XLEN-1:0]   src2_fwd_value,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_dst_num,
  output logic [XLEN-1:0]   rf_dst_value
);

  wb_entry_t       lsu_entry, fifo_head, sel;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic            lsu_acc, sel_valid;
  logic [NREG-1:0] pending_q, pending_d;

  assign lsu_ready       = ~fifo_full;
  assign lsu_acc         = lsu_valid & lsu_ready;
  assign lsu_entry.rd    = lsu_rd;
  assign lsu_entry.value = lsu_value;

  wb_fifo #(
    .Depth(LSU_DEPTH)
  ) u_lsu_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(lsu_entry),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ALU first, then buffered LSU results, then LSU bypass only when nothing is queued.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel.rd    = alu_rd;
      sel.value = alu_value;
      fifo_push = lsu_acc;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel       = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = lsu_acc;
    end else if (lsu_acc) begin
      sel_valid = 1'b1;
      sel       = lsu_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_dst_num   <= '0;
      rf_dst_value <= '0;
    end else begin
      rf_we <= sel_valid && (sel.rd != '0);
      if (sel_valid) begin
        rf_dst_num   <= sel.rd;
        rf_dst_value <= sel.value;
      end
    end
  end

  // Clear on write-back, then set, so a same-cycle re-dispatch keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (rf_we) pending_d[rf_dst_num] = 1'b0;
    if (sb_set_valid) pending_d[sb_set_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign src1_fwd       = rf_we && (rf_dst_num == src1_num) && (src1_num != '0);
  assign src2_fwd       = rf_we && (rf_dst_num == src2_num) && (src2_num != '0);
  assign src1_fwd_value = rf_dst_value;
  assign src2_fwd_value = rf_dst_value;
  assign src1_busy      = pending_q[src1_num] & ~src1_fwd;
  assign src2_busy      = pending_q[src2_num] & ~src2_fwd;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a queue-based write-back model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, lsu_ready, sb_set_valid;
  logic [4:0]  alu_rd, lsu_rd, sb_set_rd, src1_num, src2_num, rf_dst_num;
  logic [31:0] alu_value, lsu_value, src1_fwd_value, src2_fwd_value, rf_dst_value;
  logic        src1_busy, src2_busy, src1_fwd, src2_fwd, rf_we;

  regfile_wb_arbiter #(
    .LSU_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_value     (alu_value),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_value     (lsu_value),
    .sb_set_valid  (sb_set_valid),
    .sb_set_rd     (sb_set_rd),
    .src1_num      (src1_num),
    .src2_num      (src2_num),
    .src1_busy     (src1_busy),
    .src2_busy     (src2_busy),
    .src1_fwd      (src1_fwd),
    .src1_fwd_value(src1_fwd_value),
    .src2_fwd      (src2_fwd),
    .src2_fwd_value(src2_fwd_value),
    .rf_we         (rf_we),
    .rf_dst_num    (rf_dst_num),
    .rf_dst_value  (rf_dst_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  // Reference state: what the write port shows now, the LSU backlog, pending registers.
  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_num;
  logic [31:0] m_val;
  logic [31:0] m_pend;

  int n_checks = 0;
  int n_fail   = 0;

  logic        last_ready, last_busy1, last_fwd1;
  logic [31:0] last_fwdv1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_we   = 1'b0;
    m_num  = '0;
    m_val  = '0;
    m_pend = '0;
  endtask

  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] lval,
                     input logic sv, input logic [4:0] srd,
                     input logic [4:0] s1, input logic [4:0] s2);
    logic e_ready, f1, f2, acc, has;
    ent_t e, l;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_value = aval;
    lsu_valid = lv; lsu_rd = lrd; lsu_value = lval;
    sb_set_valid = sv; sb_set_rd = srd; src1_num = s1; src2_num = s2;
    #1;
    e_ready = (q.size() < DEPTH);
    f1 = m_we && (m_num == s1) && (s1 != 0);
    f2 = m_we && (m_num == s2) && (s2 != 0);
    check("lsu_ready", lsu_ready, e_ready);
    check("src1_fwd", src1_fwd, f1);
    check("src2_fwd", src2_fwd, f2);
    check("src1_fwd_value", src1_fwd_value, m_val);
    check("src2_fwd_value", src2_fwd_value, m_val);
    check("src1_busy", src1_busy, m_pend[s1] && !f1);
    check("src2_busy", src2_busy, m_pend[s2] && !f2);
    last_ready = lsu_ready; last_busy1 = src1_busy;
    last_fwd1 = src1_fwd; last_fwdv1 = src1_fwd_value;

    acc = lv && e_ready;
    l.rd = lrd; l.val = lval;
    has = 1'b0;
    e.rd = '0; e.val = '0;
    if (av) begin
      e.rd = ard; e.val = aval; has = 1'b1;
      if (acc) q.push_back(l);
    end else if (q.size() > 0) begin
      e = q.pop_front(); has = 1'b1;
      if (acc) q.push_back(l);
    end else if (acc) begin
      e = l; has = 1'b1;
    end
    if (m_we) m_pend[m_num] = 1'b0;
    if (sv && srd != 0) m_pend[srd] = 1'b1;
    if (has) begin
      m_num = e.rd;
      m_val = e.val;
    end
    m_we = has && (e.rd != 0);

    @(posedge clk);
    #1;
    check("rf_we", rf_we, m_we);
    if (m_we) begin
      check("rf_dst_num", rf_dst_num, m_num);
      check("rf_dst_value", rf_dst_value, m_val);
    end
  endtask

  task automatic idle(input logic [4:0] s1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, s1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_value = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_value = 0;
    sb_set_valid = 0; sb_set_rd = 0; src1_num = 0; src2_num = 0;
    model_clear();
    #3;
    check("reset_rf_we", rf_we, 0);
    check("reset_rf_dst_num", rf_dst_num, 0);
    check("reset_rf_dst_value", rf_dst_value, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_lsu_ready", lsu_ready, 1);

    // ALU only: visible one cycle later.
    cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    check("alu_x5_we", rf_we, 1);
    check("alu_x5_num", rf_dst_num, 5);
    check("alu_x5_val", rf_dst_value, 32'h1234);

    // Collision: ALU wins, LSU follows a cycle later.
    cyc(1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 0, 0);
    check("coll_x3_num", rf_dst_num, 3);
    check("coll_x3_val", rf_dst_value, 32'hA);
    idle(0);
    check("coll_x4_we", rf_we, 1);
    check("coll_x4_num", rf_dst_num, 4);
    check("coll_x4_val", rf_dst_value, 32'hB);
    idle(0);

    // Backpressure: third LSU offer meets a full buffer and is dropped.
    cyc(1, 10, 32'h1, 1, 11, 32'h11, 0, 0, 0, 0);
    cyc(1, 12, 32'h2, 1, 13, 32'h13, 0, 0, 0, 0);
    cyc(1, 14, 32'h3, 1, 15, 32'h15, 0, 0, 0, 0);
    check("bp_ready_low", last_ready, 0);
    cyc(1, 16, 32'h4, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    check("bp_drain1_num", rf_dst_num, 11);
    check("bp_drain1_val", rf_dst_value, 32'h11);
    idle(0);
    check("bp_drain2_num", rf_dst_num, 13);
    idle(0);
    check("bp_drained_we", rf_we, 0);

    // Scoreboard and forwarding on x7.
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7);
    check("sb_busy", last_busy1, 1);
    cyc(0, 0, 0, 1, 7, 32'h55, 0, 0, 7, 0);
    idle(7);
    check("sb_fwd", last_fwd1, 1);
    check("sb_fwd_value", last_fwdv1, 32'h55);
    check("sb_fwd_not_busy", last_busy1, 0);
    idle(7);
    check("sb_after_fwd", last_fwd1, 0);
    check("sb_after_busy", last_busy1, 0);

    // x0 is never written, pending or forwarded.
    cyc(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 0);
    check("x0_we", rf_we, 0);
    idle(0);
    check("x0_busy", last_busy1, 0);
    check("x0_fwd", last_fwd1, 0);

    // Reset with two buffered LSU results.
    cyc(1, 20, 32'h20, 1, 21, 32'h21, 0, 0, 0, 0);
    cyc(1, 22, 32'h22, 1, 23, 32'h23, 0, 0, 0, 0);
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0; sb_set_valid = 0;
    rst_n = 1'b0;
    #1;
    check("midrst_rf_we", rf_we, 0);
    check("midrst_rf_num", rf_dst_num, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", lsu_ready, 1);
    repeat (3) idle(0);

    // Random traffic; source queries sometimes aimed at the register being written.
    for (int i = 0; i < 500; i++) begin
      logic [4:0] s1, s2;
      s1 = ($urandom_range(0, 2) == 0) ? m_num : 5'($urandom_range(0, 31));
      s2 = ($urandom_range(0, 2) == 0) ? m_num : 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), s1, s2);
    end
    repeat (4) idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
